// File: rtl/visitor_direction_counter.sv
// ---------------------------------------------------------------------------
// visitor_direction_counter
//
// Sequential core of the bidirectional visitor counter. Two door sensors are
// synchronised and debounced, then a small FSM decodes the crossing order:
// A (outside) then B (inside) is an entry, B then A is an exit. The occupancy
// count saturates at 0 and MAX_COUNT. A crossing that would push the count
// past either limit is flagged with reject_p and leaves the count unchanged.
//
// Build option:
//   FULL_FLAG_EN  when defined, full is a registered (count == MAX_COUNT)
//                 flag; when undefined, full is tied to 0. Saturation and
//                 reject_p behave the same in both builds.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset (release expected to
//                         be synchronous to clk at system level)
//   sens_a    in   1      raw outer sensor, 1 = beam broken (asynchronous)
//   sens_b    in   1      raw inner sensor, 1 = beam broken (asynchronous)
//   count     out  CNT_W  current occupancy
//   entry_p   out  1      1-cycle pulse, entry counted
//   exit_p    out  1      1-cycle pulse, exit counted
//   reject_p  out  1      1-cycle pulse, crossing decoded but count saturated
//   empty     out  1      count == 0 (registered)
//   full      out  1      count == MAX_COUNT (registered, FULL_FLAG_EN only)
//
// The decoder state is held in the internal signal "state" (type state_t)
// so that checkers can bind to it directly.
// ---------------------------------------------------------------------------
module visitor_direction_counter #(
    parameter int CNT_W     = 8,
    parameter int MAX_COUNT = 99,
    parameter int DEB_CYC   = 4,
    parameter int TIMEOUT   = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sens_a,
    input  logic             sens_b,
    output logic [CNT_W-1:0] count,
    output logic             entry_p,
    output logic             exit_p,
    output logic             reject_p,
    output logic             empty,
    output logic             full
);

    localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        A_FIRST  = 2'd1,
        B_FIRST  = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    // Bit 0 = sensor A, bit 1 = sensor B throughout the input path.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       db;
    logic [DEB_W-1:0] deb_cnt [2];

    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] timer;
    logic             commit_entry;
    logic             commit_exit;

    logic [CNT_W-1:0] count_next;
    logic             entry_next;
    logic             exit_next;
    logic             reject_next;

    logic a;
    logic b;
    assign a = db[0];
    assign b = db[1];

    // Two-flop synchronisers for both sensors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sens_b, sens_a};
            sync2 <= sync1;
        end
    end

    // Debounce: the counter tracks how many consecutive samples have differed
    // from the accepted level; the DEB_CYC-th differing sample flips it. Any
    // sample equal to the accepted level restarts the run, so shorter glitches
    // never reach the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    db[i]      <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Crossing decoder state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Timer is zero whenever a *_FIRST state is entered (only reachable from
    // IDLE) and advances every cycle spent there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else begin
            case (state)
                IDLE:             timer <= '0;
                A_FIRST, B_FIRST: timer <= timer + TMR_W'(1);
                default:          timer <= timer;
            endcase
        end
    end

    // The second sensor wins over abort and timeout in the same cycle.
    // WAIT_CLR swallows everything until both beams are clear, which is what
    // guarantees a single commit per crossing.
    always_comb begin
        state_next   = state;
        commit_entry = 1'b0;
        commit_exit  = 1'b0;
        case (state)
            IDLE: begin
                if (a && b) begin
                    state_next = WAIT_CLR;
                end else if (a) begin
                    state_next = A_FIRST;
                end else if (b) begin
                    state_next = B_FIRST;
                end
            end
            A_FIRST: begin
                if (b) begin
                    commit_entry = 1'b1;
                    state_next   = WAIT_CLR;
                end else if (!a) begin
                    state_next = IDLE;
                end else if (timer == TMR_LAST) begin
                    state_next = WAIT_CLR;
                end
            end
            B_FIRST: begin
                if (a) begin
                    commit_exit = 1'b1;
                    state_next  = WAIT_CLR;
                end else if (!b) begin
                    state_next = IDLE;
                end else if (timer == TMR_LAST) begin
                    state_next = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!a && !b) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturating count update; commits are mutually exclusive by construction.
    always_comb begin
        count_next  = count;
        entry_next  = 1'b0;
        exit_next   = 1'b0;
        reject_next = 1'b0;
        if (commit_entry) begin
            if (count < MAX_C) begin
                count_next = count + CNT_W'(1);
                entry_next = 1'b1;
            end else begin
                reject_next = 1'b1;
            end
        end else if (commit_exit) begin
            if (count != '0) begin
                count_next = count - CNT_W'(1);
                exit_next  = 1'b1;
            end else begin
                reject_next = 1'b1;
            end
        end
    end

    // Flags are derived from count_next so they line up with count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            entry_p  <= 1'b0;
            exit_p   <= 1'b0;
            reject_p <= 1'b0;
            empty    <= 1'b1;
        end else begin
            count    <= count_next;
            entry_p  <= entry_next;
            exit_p   <= exit_next;
            reject_p <= reject_next;
            empty    <= (count_next == '0);
        end
    end

`ifdef FULL_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
        end else begin
            full <= (count_next == MAX_C);
        end
    end
`else
    assign full = 1'b0;
`endif

endmodule

// File: tb/tb_visitor_direction_counter.sv
// ---------------------------------------------------------------------------
// tb_visitor_direction_counter
//
// Directed table of crossing scenarios with hand-written expected count and
// pulse, randomized scenarios checked against an occupancy model that works
// purely at the level of "crossing kinds" (entry, exit, abort, timeout,
// simultaneous, glitch), and a hand-written mid-crossing reset sequence.
// ---------------------------------------------------------------------------
module tb_visitor_direction_counter;

    localparam int CNT_W = 8;
    localparam int MAXC  = 3;
    localparam int DEB   = 4;
    localparam int TMO   = 20;

    localparam logic [1:0] EV_NONE   = 2'd0;
    localparam logic [1:0] EV_ENTRY  = 2'd1;
    localparam logic [1:0] EV_EXIT   = 2'd2;
    localparam logic [1:0] EV_REJECT = 2'd3;

    localparam int K_ENTRY   = 0;
    localparam int K_EXIT    = 1;
    localparam int K_ABORT_A = 2;
    localparam int K_ABORT_B = 3;
    localparam int K_SIMUL   = 4;
    localparam int K_TMO_A   = 5;
    localparam int K_TMO_B   = 6;
    localparam int K_GLITCH_A = 7;
    localparam int K_GLITCH_B = 8;

    typedef struct {
        int         kind;
        int         len;
        int         exp_count;
        logic [1:0] exp_ev;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sens_a = 1'b0;
    logic             sens_b = 1'b0;
    logic [CNT_W-1:0] count;
    logic             entry_p;
    logic             exit_p;
    logic             reject_p;
    logic             empty;
    logic             full;

    always #5 clk = ~clk;

    visitor_direction_counter #(
        .CNT_W     (CNT_W),
        .MAX_COUNT (MAXC),
        .DEB_CYC   (DEB),
        .TIMEOUT   (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sens_a   (sens_a),
        .sens_b   (sens_b),
        .count    (count),
        .entry_p  (entry_p),
        .exit_p   (exit_p),
        .reject_p (reject_p),
        .empty    (empty),
        .full     (full)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    int         model_count = 0;
    logic       mon_en = 1'b0;
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    vec_t       vecs[19];

    // Every high cycle of a pulse is logged, so a stretched or doubled pulse
    // shows up as an extra event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (entry_p)  obs_q.push_back(EV_ENTRY);
            if (exit_p)   obs_q.push_back(EV_EXIT);
            if (reject_p) obs_q.push_back(EV_REJECT);
        end
    end

    function automatic int exp_full(input int c);
`ifdef FULL_FLAG_EN
        return (c == MAXC) ? 1 : 0;
`else
        return 0 * c;
`endif
    endfunction

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_events(input string name);
        bit ok;
        int g0;
        int w0;
        ok = (obs_q.size() == exp_q.size());
        if (ok) begin
            foreach (exp_q[i]) begin
                if (obs_q[i] != exp_q[i]) ok = 1'b0;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            g0 = (obs_q.size() > 0) ? int'(obs_q[0]) : -1;
            w0 = (exp_q.size() > 0) ? int'(exp_q[0]) : -1;
            $display("FAIL %s events: got n=%0d first=%0d want n=%0d first=%0d",
                     name, obs_q.size(), g0, exp_q.size(), w0);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input string name, input int want_count);
        check_val({name, " count"}, int'(count), want_count);
        check_val({name, " empty"}, int'(empty), (want_count == 0) ? 1 : 0);
        check_val({name, " full"},  int'(full),  exp_full(want_count));
    endtask

    // ---------------- drivers ----------------
    task automatic hold(input logic a, input logic b, input int n);
        sens_a = a;
        sens_b = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_kind(input int k, input int len);
        int tail;
        tail = ($urandom_range(0, 1) == 1) ? $urandom_range(8, 12) : 0;
        case (k)
            K_ENTRY:    begin hold(1, 0, len); hold(1, 1, 8); hold(0, 1, tail); end
            K_EXIT:     begin hold(0, 1, len); hold(1, 1, 8); hold(1, 0, tail); end
            K_ABORT_A:  hold(1, 0, len);
            K_ABORT_B:  hold(0, 1, len);
            K_SIMUL:    hold(1, 1, len);
            K_TMO_A:    begin hold(1, 0, len); hold(1, 1, 8); end
            K_TMO_B:    begin hold(0, 1, len); hold(1, 1, 8); end
            K_GLITCH_A: hold(1, 0, len);
            K_GLITCH_B: hold(0, 1, len);
            default:    hold(0, 0, len);
        endcase
        hold(0, 0, 14);
    endtask

    // Occupancy model: only completed entries/exits move the count, clamped
    // to [0, MAXC]; a clamped crossing yields a reject event instead.
    task automatic model_kind(input int k);
        if (k == K_ENTRY) begin
            if (model_count < MAXC) begin
                model_count++;
                exp_q.push_back(EV_ENTRY);
            end else begin
                exp_q.push_back(EV_REJECT);
            end
        end else if (k == K_EXIT) begin
            if (model_count > 0) begin
                model_count--;
                exp_q.push_back(EV_EXIT);
            end else begin
                exp_q.push_back(EV_REJECT);
            end
        end
    endtask

    function automatic int rand_len(input int k);
        if (k == K_TMO_A || k == K_TMO_B) return $urandom_range(28, 36);
        if (k == K_GLITCH_A || k == K_GLITCH_B) return $urandom_range(1, 3);
        return $urandom_range(8, 14);
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        vecs[0]  = '{K_ENTRY,    10, 1, EV_ENTRY};
        vecs[1]  = '{K_ENTRY,    12, 2, EV_ENTRY};
        vecs[2]  = '{K_EXIT,     10, 1, EV_EXIT};
        vecs[3]  = '{K_GLITCH_A,  3, 1, EV_NONE};
        vecs[4]  = '{K_GLITCH_B,  3, 1, EV_NONE};
        vecs[5]  = '{K_ENTRY,    10, 2, EV_ENTRY};
        vecs[6]  = '{K_ENTRY,     9, 3, EV_ENTRY};
        vecs[7]  = '{K_ENTRY,    10, 3, EV_REJECT};
        vecs[8]  = '{K_EXIT,     10, 2, EV_EXIT};
        vecs[9]  = '{K_EXIT,     11, 1, EV_EXIT};
        vecs[10] = '{K_EXIT,     10, 0, EV_EXIT};
        vecs[11] = '{K_EXIT,     10, 0, EV_REJECT};
        vecs[12] = '{K_TMO_A,    30, 0, EV_NONE};
        vecs[13] = '{K_SIMUL,    10, 0, EV_NONE};
        vecs[14] = '{K_ABORT_A,  10, 0, EV_NONE};
        vecs[15] = '{K_ABORT_B,  10, 0, EV_NONE};
        vecs[16] = '{K_ENTRY,    10, 1, EV_ENTRY};
        vecs[17] = '{K_TMO_B,    30, 1, EV_NONE};
        vecs[18] = '{K_EXIT,     10, 0, EV_EXIT};

        // Reset values while reset is held.
        repeat (5) @(posedge clk);
        #1;
        check_state("reset", 0);
        check_val("reset pulses", int'({entry_p, exit_p, reject_p}), 0);

        // 50 idle cycles after release: nothing happens.
        rst_n  = 1'b1;
        mon_en = 1'b1;
        hold(0, 0, 50);
        check_events("idle50");
        check_state("idle50", 0);

        // Directed table.
        foreach (vecs[i]) begin
            run_kind(vecs[i].kind, vecs[i].len);
            if (vecs[i].exp_ev != EV_NONE) exp_q.push_back(vecs[i].exp_ev);
            check_events($sformatf("vec%0d", i));
            check_state($sformatf("vec%0d", i), vecs[i].exp_count);
        end
        model_count = vecs[18].exp_count;

        // Randomized crossings against the occupancy model.
        for (int n = 0; n < 40; n++) begin
            int k;
            k = $urandom_range(0, 8);
            model_kind(k);
            run_kind(k, rand_len(k));
            check_events($sformatf("rnd%0d k%0d", n, k));
            check_state($sformatf("rnd%0d", n), model_count);
        end

        // Reset in the middle of a crossing.
        hold(0, 0, 4);
        model_kind(K_ENTRY);
        run_kind(K_ENTRY, 10);
        check_events("pre_reset");
        sens_a = 1'b1;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_state("mid_reset", 0);
        model_count = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // A still blocked becomes a fresh first event, then aborts; a lone B
        // afterwards also aborts. Nothing may be counted.
        hold(1, 0, 12);
        hold(0, 0, 10);
        hold(0, 1, 10);
        hold(0, 0, 14);
        check_events("post_reset");
        check_state("post_reset", 0);

        // A normal crossing still works after the reset.
        model_kind(K_ENTRY);
        run_kind(K_ENTRY, 10);
        check_events("after_reset_entry");
        check_state("after_reset_entry", model_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
